// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done bundle between the sequencer (master) and the subtractor (slave).
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::WIDTH_DEFAULT
);

  // Handshake: start is sampled only while busy is low. Operands are captured on
  // that edge. busy then stays high for WIDTH+1 cycles. The last of those cycles
  // carries a one-cycle done pulse, and diff/bout/ovf are valid from that cycle
  // until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , ovf
`endif
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, one shared cell.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus,
  output state_t             fsm_state
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] d_sr;
  logic             br;
  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] d_cat;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_q;
`endif

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (cnt == CNT_LAST);
  // d_sr holds the first WIDTH-1 result bits; the cell supplies the MSB on the last step.
  assign d_cat  = {d_bit, d_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      br     <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        br   <= bus.bin;
        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br   <= br_next;
        d_sr <= d_cat[WIDTH-1:1];
        if (!last) cnt <= cnt + 1'b1;
      end
      // Results land on the edge entering DONE so they are valid with the done pulse.
      done_q <= last;
      if (last) begin
        diff_q <= d_cat;
        bout_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
      end
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
  assign fsm_state = state;

endmodule
